lane_overlay: RTL
=================

// Module: lane_overlay
// PURPOSE
//  Downstream of the lane detector. Captures left/right lane endpoints on each detection_done
//  and computes per-lane slopes with a serial divider. Draws both lanes as coloured bands on
//  the RGB565 stream in the next frame, with a hold-over when detection drops out.
// PARAMETERS
//  IMG_WIDTH     640     active pixels per line
//  ROI_TOP       240     first row of drawn lane segment (matches detector ROI)
//  ROI_BOTTOM    460     last row of drawn lane segment; DY = ROI_BOTTOM-ROI_TOP (220)
//  LINE_HALF_W   2       band half-width in pixels (band = 2*LINE_HALF_W+1)
//  MISS_LIMIT    4       consecutive invalid frames before a lane stops being drawn
//  LEFT_COLOR    16'hF800  RGB565 colour for left lane
//  RIGHT_COLOR   16'h07E0  RGB565 colour for right lane
// PORTS
//  clk               in   1   pixel clock
//  rst               in   1   asynchronous, active-high reset
//  frame_start       in   1   1-cycle pulse before first pixel of a frame
//  pixel_valid       in   1   pixel_rgb/pixel_x/pixel_y valid
//  pixel_x           in   10  column of current pixel
//  pixel_y           in   10  row of current pixel
//  pixel_rgb         in   16  RGB565 video pixel
//  detection_done    in   1   1-cycle pulse: lane fields below are valid
//  left_lane_valid   in   1   left lane found this frame
//  left_x_top        in   10  left lane x at ROI_TOP
//  left_x_bottom     in   10  left lane x at ROI_BOTTOM
//  right_lane_valid  in   1   right lane found this frame
//  right_x_top       in   10  right lane x at ROI_TOP
//  right_x_bottom    in   10  right lane x at ROI_BOTTOM
//  pixel_out         out  16  RGB565 output with overlay
//  pixel_valid_out   out  1   pixel_out valid
//  left_draw_en      out  1   left lane drawn in current frame
//  right_draw_en     out  1   right lane drawn in current frame
//  slope_busy        out  1   serial divider running
// BEHAVIOUR
//  Reset: all outputs 0; shadow/active lane regs 0; miss counters = MISS_LIMIT (nothing drawn); FSM IDLE.
//  Capture on detection_done, per side:
//  - valid=1 -> latch x_top, x_bottom into shadow; miss_cnt <= 0.
//  - valid=0 -> shadow unchanged; miss_cnt saturating-increments up to MISS_LIMIT.
//  - Then start divider.
//  Slope FSM: IDLE -> DIV_L (18 cyc) -> DIV_R (18 cyc) -> READY -> IDLE; slope_busy=1 outside IDLE/READY.
//  - Restoring divide: q = (|x_bottom-x_top| << 8) / DY, truncated; 18-bit unsigned.
//  - step = sign(x_bottom-x_top) ? -q : q, signed 19-bit Q10.8.
//  - detection_done while busy: recapture and restart at DIV_L; partial results discarded.
//  - READY sets slopes_ok; FSM returns to IDLE the next cycle.
//  frame_start: if slopes_ok, copy shadow (x_top, step) and draw_en into active regs, then clear slopes_ok.
//  - Otherwise active regs keep previous frame values.
//  - draw_en = (miss_cnt < MISS_LIMIT).
//  - Simultaneous frame_start + detection_done: frame_start uses the pre-capture state; new capture affects next frame.
//  Row walker, per side, pos signed 19-bit Q10.8:
//  - pos <= x_top<<8 on frame_start.
//  - pos <= pos + step when pixel_valid & pixel_x==IMG_WIDTH-1 & ROI_TOP<=pixel_y<ROI_BOTTOM.
//  - Rows at or after ROI_BOTTOM: pos held.
//  Match: pixel_y in [ROI_TOP,ROI_BOTTOM] & draw_en & |pixel_x - pos[18:8]| <= LINE_HALF_W, signed compare.
//  - Off-screen pos simply never matches; no wrap.
//  Output, 1-cycle latency: pixel_valid_out <= pixel_valid.
//  - pixel_out <= left match ? LEFT_COLOR : right match ? RIGHT_COLOR : pixel_rgb.
//  - Left wins on overlap.
//  - pixel_out holds last value when pixel_valid=0.
//  Mid-frame reset: all state cleared; drawing resumes only after next capture, slope and frame_start.
// TESTING
//  1. Left top=100 bottom=320 valid -> step=+256; next frame row 350 px 208..212 = F800, px 207/213 = pixel_rgb.
//  2. Right top=500 bottom=390 valid -> step=-128; row 300 centre x=470, band 468..472 = 07E0.
//  3. Left valid once, then 4 invalid frames -> drawn frames 2-4 at old position; left_draw_en=0 from frame 5.
//  4. detection_done again 5 cycles into DIV_L -> restart; slope_busy high 36 cycles after last pulse; new values used.
//  5. Left and right band both at x=320, row 400 -> F800 output.
//  6. Assert rst mid-row 300 -> pixel_out=0, pixel_valid_out=0 next edge; no overlay until recapture and frame_start.

Source files
------------

// File: rtl/lane_overlay_if.sv
// Video, detection and overlay-output bundle for lane_overlay.
// The video/detector side is the master; lane_overlay is the slave.
interface lane_overlay_if;
  logic        frame_start;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] pixel_rgb;
  logic        detection_done;
  logic        left_lane_valid;
  logic [9:0]  left_x_top;
  logic [9:0]  left_x_bottom;
  logic        right_lane_valid;
  logic [9:0]  right_x_top;
  logic [9:0]  right_x_bottom;
  logic [15:0] pixel_out;
  logic        pixel_valid_out;
  logic        left_draw_en;
  logic        right_draw_en;
  logic        slope_busy;

  modport master (
    output frame_start, pixel_valid, pixel_x, pixel_y, pixel_rgb,
    output detection_done, left_lane_valid, left_x_top, left_x_bottom,
    output right_lane_valid, right_x_top, right_x_bottom,
    input  pixel_out, pixel_valid_out, left_draw_en, right_draw_en, slope_busy
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_x, pixel_y, pixel_rgb,
    input  detection_done, left_lane_valid, left_x_top, left_x_bottom,
    input  right_lane_valid, right_x_top, right_x_bottom,
    output pixel_out, pixel_valid_out, left_draw_en, right_draw_en, slope_busy
  );
endinterface

// File: rtl/lane_overlay.sv
// Lane overlay: captures detector endpoints, derives per-lane slopes with a serial
// divider and paints both lanes as coloured bands on the following frame.
//
// state | meaning
// IDLE  | waiting for detection_done
// DIV_L | 18-cycle restoring divide for the left slope
// DIV_R | 18-cycle restoring divide for the right slope
// READY | both slopes done; flag them for the next frame_start
module lane_overlay #(
  parameter int          IMG_WIDTH   = 640,
  parameter int          ROI_TOP     = 240,
  parameter int          ROI_BOTTOM  = 460,
  parameter int          LINE_HALF_W = 2,
  parameter int          MISS_LIMIT  = 4,
  parameter logic [15:0] LEFT_COLOR  = 16'hF800,
  parameter logic [15:0] RIGHT_COLOR = 16'h07E0
) (
  input logic           clk,
  input logic           rst,
  lane_overlay_if.slave bus
);

  localparam logic [8:0]         DY       = 9'(ROI_BOTTOM - ROI_TOP);
  localparam logic [9:0]         X_LAST   = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]         Y_TOP    = 10'(ROI_TOP);
  localparam logic [9:0]         Y_BOT    = 10'(ROI_BOTTOM);
  localparam logic [2:0]         MISS_MAX = 3'(MISS_LIMIT);
  localparam logic signed [11:0] HALF_W   = 12'(LINE_HALF_W);
  localparam logic [4:0]         DIV_LAST = 5'd17;

  typedef enum logic [1:0] {IDLE, DIV_L, DIV_R, READY} state_t;
  state_t state, state_nx;

  logic [9:0]         sh_l_top, sh_l_bot, sh_r_top, sh_r_bot;
  logic [2:0]         miss_l, miss_r;
  logic signed [18:0] sh_l_step, sh_r_step;
  logic               slopes_ok;

  logic [9:0]         act_l_top, act_r_top;
  logic signed [18:0] act_l_step, act_r_step;
  logic               act_l_en, act_r_en;

  logic [17:0]        div_n;
  logic [7:0]         rem;
  logic               div_neg;
  logic [4:0]         div_cnt;

  logic signed [18:0] pos_l, pos_r;

  logic               load_l, load_r, div_step, store_l, store_r, set_ok;

  function automatic logic [17:0] dividend(input logic [9:0] top, input logic [9:0] bot);
    logic [9:0] d;
    d = (bot >= top) ? bot - top : top - bot;
    return {d, 8'h00};
  endfunction

  // Invalid side keeps its shadow, so the divider re-derives the old slope.
  logic [9:0] cap_l_top, cap_l_bot, cap_r_top, cap_r_bot;
  assign cap_l_top = bus.left_lane_valid  ? bus.left_x_top     : sh_l_top;
  assign cap_l_bot = bus.left_lane_valid  ? bus.left_x_bottom  : sh_l_bot;
  assign cap_r_top = bus.right_lane_valid ? bus.right_x_top    : sh_r_top;
  assign cap_r_bot = bus.right_lane_valid ? bus.right_x_bottom : sh_r_bot;

  logic [8:0]         trial;
  logic               fits;
  logic [7:0]         rem_nx;
  logic [17:0]        quo_nx;
  logic signed [18:0] step_nx;
  assign trial   = {rem, div_n[17]};
  assign fits    = (trial >= DY);
  assign rem_nx  = fits ? 8'(trial - DY) : trial[7:0];
  assign quo_nx  = {div_n[16:0], fits};
  assign step_nx = div_neg ? -$signed({1'b0, quo_nx}) : $signed({1'b0, quo_nx});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_l   = 1'b0;
    load_r   = 1'b0;
    div_step = 1'b0;
    store_l  = 1'b0;
    store_r  = 1'b0;
    set_ok   = 1'b0;
    if (bus.detection_done) begin
      state_nx = DIV_L;
      load_l   = 1'b1;
    end else begin
      case (state)
        DIV_L: begin
          div_step = 1'b1;
          if (div_cnt == 5'd0) begin
            store_l  = 1'b1;
            load_r   = 1'b1;
            state_nx = DIV_R;
          end
        end
        DIV_R: begin
          div_step = 1'b1;
          if (div_cnt == 5'd0) begin
            store_r  = 1'b1;
            state_nx = READY;
          end
        end
        READY: begin
          set_ok   = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.slope_busy = (state == DIV_L) || (state == DIV_R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_n   <= '0;
      rem     <= '0;
      div_neg <= 1'b0;
      div_cnt <= '0;
    end else if (load_l) begin
      div_n   <= dividend(cap_l_top, cap_l_bot);
      rem     <= '0;
      div_neg <= (cap_l_bot < cap_l_top);
      div_cnt <= DIV_LAST;
    end else if (load_r) begin
      div_n   <= dividend(sh_r_top, sh_r_bot);
      rem     <= '0;
      div_neg <= (sh_r_bot < sh_r_top);
      div_cnt <= DIV_LAST;
    end else if (div_step) begin
      div_n   <= quo_nx;
      rem     <= rem_nx;
      div_cnt <= div_cnt - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_l_top  <= '0;
      sh_l_bot  <= '0;
      sh_r_top  <= '0;
      sh_r_bot  <= '0;
      miss_l    <= MISS_MAX;
      miss_r    <= MISS_MAX;
      sh_l_step <= '0;
      sh_r_step <= '0;
      slopes_ok <= 1'b0;
    end else begin
      if (bus.detection_done) begin
        sh_l_top <= cap_l_top;
        sh_l_bot <= cap_l_bot;
        sh_r_top <= cap_r_top;
        sh_r_bot <= cap_r_bot;
        miss_l   <= bus.left_lane_valid  ? 3'd0 : (miss_l < MISS_MAX) ? miss_l + 3'd1 : miss_l;
        miss_r   <= bus.right_lane_valid ? 3'd0 : (miss_r < MISS_MAX) ? miss_r + 3'd1 : miss_r;
      end
      if (store_l) sh_l_step <= step_nx;
      if (store_r) sh_r_step <= step_nx;
      if (set_ok)                                     slopes_ok <= 1'b1;
      else if (bus.detection_done || bus.frame_start) slopes_ok <= 1'b0;
    end
  end

  // frame_start sees pre-capture shadow state, so a coincident capture lands next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_l_top  <= '0;
      act_r_top  <= '0;
      act_l_step <= '0;
      act_r_step <= '0;
      act_l_en   <= 1'b0;
      act_r_en   <= 1'b0;
    end else if (bus.frame_start && slopes_ok) begin
      act_l_top  <= sh_l_top;
      act_r_top  <= sh_r_top;
      act_l_step <= sh_l_step;
      act_r_step <= sh_r_step;
      act_l_en   <= (miss_l < MISS_MAX);
      act_r_en   <= (miss_r < MISS_MAX);
    end
  end

  assign bus.left_draw_en  = act_l_en;
  assign bus.right_draw_en = act_r_en;

  logic [9:0] top_l_now, top_r_now;
  logic       row_end;
  assign top_l_now = (bus.frame_start && slopes_ok) ? sh_l_top : act_l_top;
  assign top_r_now = (bus.frame_start && slopes_ok) ? sh_r_top : act_r_top;
  assign row_end   = bus.pixel_valid && (bus.pixel_x == X_LAST) &&
                     (bus.pixel_y >= Y_TOP) && (bus.pixel_y < Y_BOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_l <= '0;
      pos_r <= '0;
    end else if (bus.frame_start) begin
      pos_l <= {1'b0, top_l_now, 8'h00};
      pos_r <= {1'b0, top_r_now, 8'h00};
    end else if (row_end) begin
      pos_l <= pos_l + act_l_step;
      pos_r <= pos_r + act_r_step;
    end
  end

  logic signed [11:0] px_s, diff_l, diff_r;
  logic               in_roi, hit_l, hit_r;
  assign px_s   = $signed({2'b00, bus.pixel_x});
  assign diff_l = px_s - $signed({pos_l[18], pos_l[18:8]});
  assign diff_r = px_s - $signed({pos_r[18], pos_r[18:8]});
  assign in_roi = (bus.pixel_y >= Y_TOP) && (bus.pixel_y <= Y_BOT);
  assign hit_l  = act_l_en && in_roi && (diff_l >= -HALF_W) && (diff_l <= HALF_W);
  assign hit_r  = act_r_en && in_roi && (diff_r >= -HALF_W) && (diff_r <= HALF_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pixel_out       <= '0;
      bus.pixel_valid_out <= 1'b0;
    end else begin
      bus.pixel_valid_out <= bus.pixel_valid;
      if (bus.pixel_valid)
        bus.pixel_out <= hit_l ? LEFT_COLOR : hit_r ? RIGHT_COLOR : bus.pixel_rgb;
    end
  end

endmodule
